// File: rtl/wlm_iter.sv
`default_nettype none
// ============================================================================
// Module   : wlm_iter
// Brief    : Iterative word-level Montgomery reduction, T = C * 2^(-W*L) mod q,
//            q = qH*2^W + 1, one W-bit word retired per RUN cycle.
// Revision : 1.0
// ============================================================================
module wlm_iter #(
    parameter int LOGQ    = 60,
    parameter int LOGQH   = 43,
    parameter int CORRECT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LOGQH-1:0]    qH,
    input  logic [2*LOGQ-1:0]   C,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LOGQ:0]       T,
    output logic                busy
);

    localparam int W    = LOGQ - LOGQH;
    localparam int L    = (LOGQ + W - 1) / W;
    localparam int LAT  = L + 1;
    localparam int ACCW = 2 * LOGQ + 1;
    localparam int CW   = (L > 1) ? $clog2(L) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_CORR = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ACCW-1:0]  r_acc;
    logic [LOGQH-1:0] r_qh;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [LOGQ:0]    r_t;

    logic             w_in_ready;
    logic             w_busy;
    logic             w_accept;
    logic             w_last;
    logic [W-1:0]     w_cl;
    logic [W-1:0]     w_m;
    logic [LOGQ-1:0]  w_prod;
    logic [ACCW-1:0]  w_next;
    logic [LOGQ:0]    w_q;
    logic [LOGQ:0]    w_res;

    assign w_accept = in_valid & w_in_ready;
    assign w_last   = (r_cnt == CW'(L - 1));

    // Adding m*q clears the low word; the carry out of CL + m is exactly (CL != 0).
    assign w_cl   = r_acc[W-1:0];
    assign w_m    = -w_cl;
    assign w_prod = {{LOGQH{1'b0}}, w_m} * {{W{1'b0}}, r_qh};
    assign w_next = (r_acc >> W)
                  + {{(ACCW-LOGQ){1'b0}}, w_prod}
                  + {{(ACCW-1){1'b0}}, (w_cl != '0)};

    assign w_q = {1'b0, r_qh, {W{1'b0}}} + {{LOGQ{1'b0}}, 1'b1};

    generate
        if (CORRECT != 0) begin : g_corr
            logic w_ge;
            // After L iterations A < 2q, so one conditional subtract suffices
            // and the difference fits in LOGQ+1 bits.
            assign w_ge  = (r_acc >= {{(ACCW-LOGQ-1){1'b0}}, w_q});
            assign w_res = w_ge ? (r_acc[LOGQ:0] - w_q) : r_acc[LOGQ:0];
        end else begin : g_raw
            assign w_res = r_acc[LOGQ:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN:  if (w_last)   w_state_nxt = S_CORR;
            S_CORR: w_state_nxt = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = in_valid ? S_RUN : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            S_IDLE: w_in_ready = 1'b1;
            S_RUN:  w_busy     = 1'b1;
            S_CORR: w_busy     = 1'b1;
            S_DONE: w_in_ready = out_ready;
            default: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_qh        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_t         <= '0;
        end else begin
            if (w_accept) begin
                r_qh  <= qH;
                r_acc <= {1'b0, C};
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_next;
                r_cnt <= r_cnt + CW'(1);
            end

            if (r_state == S_CORR) begin
                r_t         <= w_res;
                r_out_valid <= 1'b1;
            end else if ((r_state == S_DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign T         = r_t;

endmodule
`default_nettype wire

// File: tb/tb_wlm_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wlm_iter
// Brief    : Directed checks on small instances plus random scoreboard run
//            on the default-parameter instance.
// Revision : 1.0
// ============================================================================
module tb_wlm_iter;

    localparam int NRAND  = 1000;
    localparam int W_B    = 17;
    localparam int L_B    = 4;
    localparam int LAT_B  = 5;
    localparam int LIMIT  = 40000;

    logic clk;
    logic rst;

    // small instances: LOGQ=8, LOGQH=4, shared stimulus
    logic        s_in_valid;
    logic [3:0]  s_qH;
    logic [15:0] s_C;
    logic        s_out_ready;
    logic        s_in_ready1, s_ov1, s_busy1;
    logic [8:0]  s_T1;
    logic        s_in_ready0, s_ov0, s_busy0;
    logic [8:0]  s_T0;

    // default instance
    logic         b_in_valid;
    logic [42:0]  b_qH;
    logic [119:0] b_C;
    logic         b_out_ready;
    logic         b_in_ready, b_ov, b_busy;
    logic [60:0]  b_T;

    int n_chk  = 0;
    int n_pass = 0;

    wlm_iter #(.LOGQ(8), .LOGQH(4), .CORRECT(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready1),
        .qH(s_qH), .C(s_C), .out_valid(s_ov1), .out_ready(s_out_ready),
        .T(s_T1), .busy(s_busy1));

    wlm_iter #(.LOGQ(8), .LOGQH(4), .CORRECT(0)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready0),
        .qH(s_qH), .C(s_C), .out_valid(s_ov0), .out_ready(s_out_ready),
        .T(s_T0), .busy(s_busy0));

    wlm_iter u_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .qH(b_qH), .C(b_C), .out_valid(b_ov), .out_ready(b_out_ready),
        .T(b_T), .busy(b_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // C * 2^(-k) mod q via repeated modular halving (q odd)
    function automatic logic [127:0] ref_mont(input logic [127:0] c, input logic [127:0] q, input int k);
        logic [127:0] x;
        x = c % q;
        for (int i = 0; i < k; i++) x = x[0] ? ((x + q) >> 1) : (x >> 1);
        return x;
    endfunction

    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (s_ov1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_small(input string tag, input logic [15:0] c, input logic [8:0] e1, input logic [8:0] e0);
        int lat;
        s_in_valid = 1'b1; s_C = c; s_qH = 4'd15; s_out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, s_in_ready1, 1'b1);
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_C = 16'($urandom); s_qH = 4'($urandom);
        wait_out(lat);
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_T"}, s_T1, e1);
        chk({tag, "_T_raw"}, {s_ov0, s_T0}, {1'b1, e0});
        @(posedge clk); #1;
        chk({tag, "_idle"}, {s_ov1, s_busy1, s_in_ready1}, 3'b001);
    endtask

    logic [127:0] expq[$];
    logic [127:0] qv, q2, cval;
    logic [63:0]  r64;
    int nacc, nres, acc_cyc, cyc, lat;
    logic prev_ov, flag;

    initial begin
        rst = 1'b0;
        s_in_valid = 1'b0; s_qH = '0; s_C = '0; s_out_ready = 1'b1;
        b_in_valid = 1'b0; b_qH = '0; b_C = '0; b_out_ready = 1'b1;
        #3;
        chk("reset_out", {s_ov1, s_busy1, s_T1}, 11'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", s_in_ready1, 1'b1);

        run_small("c256", 16'd256, 9'd1, 9'd1);
        run_small("cmax", 16'd58080, 9'd16, 9'd257);
        run_small("c0", 16'd0, 9'd0, 9'd0);
        run_small("c1280", 16'd1280, 9'd5, 9'd5);

        // stall: result held, new operands refused until out_ready
        s_in_valid = 1'b1; s_C = 16'd1280; s_qH = 4'd15; s_out_ready = 1'b0;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        wait_out(lat);
        chk("stall_lat", lat, 3);
        for (int i = 0; i < 10; i++) begin
            s_in_valid = 1'b1; s_C = 16'($urandom); s_qH = 4'($urandom);
            #1;
            chk("stall_in_ready", s_in_ready1, 1'b0);
            @(posedge clk); #1;
            chk("stall_hold", {s_ov1, s_T1}, {1'b1, 9'd5});
        end
        s_in_valid = 1'b1; s_C = 16'd256; s_qH = 4'd15; s_out_ready = 1'b1;
        #1;
        chk("swap_in_ready", s_in_ready1, 1'b1);
        @(posedge clk); #1;
        chk("swap_state", {s_ov1, s_busy1}, 2'b01);
        s_in_valid = 1'b0;
        wait_out(lat);
        chk("swap_lat", lat, 3);
        chk("swap_T", s_T1, 9'd1);
        @(posedge clk); #1;

        // reset in the middle of RUN
        s_in_valid = 1'b1; s_C = 16'd1280; s_qH = 4'd15; s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_run_busy", s_busy1, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_reset", {s_ov1, s_busy1, s_T1}, 11'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_in_ready", s_in_ready1, 1'b1);
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (s_ov1 || s_ov0) flag = 1'b1;
        end
        chk("no_partial_result", flag, 1'b0);
        run_small("post_reset", 16'd256, 9'd1, 9'd1);

        // random scoreboard on the default instance
        nacc = 0; nres = 0; acc_cyc = 0; cyc = 0; prev_ov = 1'b0;
        while ((nacc < NRAND || expq.size() != 0) && cyc < LIMIT) begin
            @(posedge clk); cyc++; #1;
            if (b_ov && !prev_ov) chk("big_lat", cyc - acc_cyc, LAT_B);
            prev_ov = b_ov;
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_valid  = (nacc < NRAND) && ($urandom_range(0, 3) != 0);
            r64 = {$urandom, $urandom};
            b_qH = r64[42:0];
            if (b_qH == '0) b_qH = 43'd1;
            qv = ({85'd0, b_qH} << W_B) + 128'd1;
            q2 = qv * qv;
            cval = {$urandom, $urandom, $urandom, $urandom} % q2;
            b_C = cval[119:0];
            #1;
            if (b_ov && b_out_ready) begin
                if (expq.size() == 0) chk("big_dup", 1'b1, 1'b0);
                else chk("big_T", b_T, expq.pop_front());
                nres++;
            end
            if (b_in_valid && b_in_ready) begin
                expq.push_back(ref_mont(cval, qv, W_B * L_B));
                acc_cyc = cyc + 1;
                nacc++;
            end
        end
        chk("big_timeout", (cyc < LIMIT), 1'b1);
        chk("big_count", nres, NRAND);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wlm_iter.md
WLM_ITER -- requirements
Module: wlm_iter

Interface
REQ-001 Parameter LOGQ, default 60: modulus width in bits; q = qH*2^W + 1.
REQ-002 Parameter LOGQH, default 43: qH width in bits.
REQ-003 Parameter CORRECT, default 1: 1 = fully reduced output; 0 = no final subtraction.
REQ-004 Localparams: W = LOGQ-LOGQH (word size); L = ceil(LOGQ/W) (iterations); LAT = L+1 (accept-to-result cycles), readable hierarchically by benches.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  C/qH offered.
REQ-008 in_ready  output  1  block can accept an operand.
REQ-009 qH  input  LOGQH  modulus high part; sampled with C on accept.
REQ-010 C  input  2*LOGQ  value to reduce; C < q^2 required.
REQ-011 out_valid  output  1  T holds a valid result.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 T  output  LOGQ+1  result; MSB always 0 when CORRECT=1.
REQ-014 busy  output  1  high in RUN or CORR.

Function
REQ-015 FSM states IDLE, RUN, CORR, DONE; reset state IDLE.
REQ-016 in_ready = 1 in IDLE, or in DONE while out_ready=1; 0 otherwise.
REQ-017 Accept = in_valid & in_ready at an edge: latch qH, load accumulator A <- C, iteration counter <- 0, go RUN.
REQ-018 RUN, each edge: CL = A[W-1:0], m = (2^W - CL) mod 2^W, A <- (A >> W) + m*qH + (CL != 0); counter +1; after the L-th iteration go CORR.
REQ-019 Accumulator width 2*LOGQ+1 bits; no truncation in any iteration.
REQ-020 CORR edge: CORRECT=1: T <- (A >= q) ? A-q : A; CORRECT=0: T <- A[LOGQ:0]; go DONE, out_valid <- 1.
REQ-021 Result: T ≡ C*2^(-W*L) mod q; CORRECT=1 gives 0 <= T < q; CORRECT=0 gives 0 <= T < 2q.
REQ-022 Latency: out_valid rises exactly LAT edges after the accept edge.
REQ-023 DONE with out_ready=0: T, out_valid held stable; in_valid ignored.
REQ-024 DONE with out_ready=1, in_valid=0: out_valid <- 0, go IDLE.
REQ-025 DONE with out_ready=1, in_valid=1 (same edge): result consumed and new operand accepted; go RUN; out_valid <- 0; steady throughput one result per L+2 cycles.
REQ-026 Changes on qH/C while not accepting have no effect on the operation in flight.
REQ-027 out_valid never asserted in IDLE, RUN or CORR.

Reset
REQ-028 rst=0 forces state IDLE, out_valid=0, busy=0, T=0, accumulator=0, counter=0, asynchronously, in any state including mid-RUN; in_ready=1 from the first edge after release.
REQ-029 An operation interrupted by reset is discarded; no partial result emitted afterwards.

Verification (LOGQ=8, LOGQH=4 -> W=4, L=2, LAT=3; qH=15 -> q=241)
REQ-030 C=256 accepted, out_ready=1 -> out_valid rises 3 edges after accept, T=1; then IDLE.
REQ-031 C=58080 (q^2-1) -> T=16 (exercises final subtraction, pre-correction A=257); CORRECT=0 instance -> T=257.
REQ-032 C=0 -> T=0; C=1280 -> T=5.
REQ-033 out_ready=0 for 10 cycles after result -> T, out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> simultaneous consume and accept, next result 4 cycles later.
REQ-034 rst pulled low during RUN -> out_valid=0, busy=0 immediately; after release, new C=256 yields T=1 with LAT=3.
REQ-035 Default parameters (LOGQ=60, LOGQH=43): LAT=5; 1000 random C < q^2 with random qH and random out_ready stalls, all T match reference model, no result lost or duplicated.
